// File: rtl/telemetry_reader.sv
// Sweeps the target telemetry bank and streams each target's record as bytes over valid/ready.
// Optional per-record XOR checksum byte: define TELEM_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; no stream output
// ADDR  | readSel driven with the current target index
// CAPT  | bank outputs captured into the holding registers
// SEND  | record bytes emitted from the holding registers
module telemetry_reader #(
    parameter int NUM_TARGETS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] readSel,
    input  logic [7:0] readX,
    input  logic [7:0] readY,
    input  logic [7:0] readZ,
    input  logic [7:0] readT,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       outLast,
    output logic       busy,
    output logic       done
);

`ifdef TELEM_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif
    localparam logic [3:0] LAST_IDX = 4'(NUM_TARGETS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, CAPT, SEND} state_t;

    state_t     state, state_nxt;
    logic [3:0] idx;
    logic [2:0] cnt;
    logic [7:0] hold_x, hold_y, hold_z, hold_t;
    logic [7:0] header;
    logic       done_r;
    logic       fire, rec_end, sweep_end;

    assign header    = {4'hA, idx};
    assign fire      = outValid && outReady;
    assign rec_end   = fire && (cnt == LAST_BYTE);
    assign sweep_end = rec_end && (idx == LAST_IDX);
    assign readSel   = idx;
    assign done      = done_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ADDR;
            ADDR: state_nxt = CAPT;
            CAPT: state_nxt = SEND;
            SEND: if (rec_end) state_nxt = (idx == LAST_IDX) ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Index returns to 0 at the end of a sweep so readSel rests at 0 in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx    <= 4'd0;
            cnt    <= 3'd0;
            hold_x <= 8'd0;
            hold_y <= 8'd0;
            hold_z <= 8'd0;
            hold_t <= 8'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= sweep_end;
            if (state == IDLE && start) idx <= 4'd0;
            if (rec_end) idx <= sweep_end ? 4'd0 : idx + 4'd1;
            if (state == CAPT) begin
                cnt    <= 3'd0;
                hold_x <= readX;
                hold_y <= readY;
                hold_z <= readZ;
                hold_t <= readT;
            end else if (fire) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    always_comb begin
        outData  = 8'd0;
        outValid = 1'b0;
        outLast  = 1'b0;
        busy     = (state != IDLE);
        if (state == SEND) begin
            outValid = 1'b1;
            outLast  = (cnt == LAST_BYTE) && (idx == LAST_IDX);
            case (cnt)
                3'd0:    outData = header;
                3'd1:    outData = hold_x;
                3'd2:    outData = hold_y;
                3'd3:    outData = hold_z;
                3'd4:    outData = hold_t;
`ifdef TELEM_CHECKSUM_EN
                3'd5:    outData = header ^ hold_x ^ hold_y ^ hold_z ^ hold_t;
`endif
                default: outData = 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_reader.sv
// Directed bench for telemetry_reader: full sweeps, stalls, held start, mid-sweep reset, bank rewrite.
module tb_telemetry_reader;
`ifdef TELEM_CHECKSUM_EN
    localparam int REC = 6;
`else
    localparam int REC = 5;
`endif
    localparam int NT = 16;

    logic       clk = 1'b0;
    logic       rst, start, outReady;
    logic [3:0] readSel;
    logic [7:0] readX, readY, readZ, readT;
    logic [7:0] outData;
    logic       outValid, outLast, busy, done;

    logic [7:0] bx [NT];
    logic [7:0] by [NT];
    logic [7:0] bz [NT];
    logic [7:0] bt [NT];
    logic [7:0] ex [NT];
    logic [7:0] ey [NT];
    logic [7:0] ez [NT];
    logic [7:0] et [NT];
    logic [7:0] got [256];
    int nb, lastcnt, lastidx;
    bit poke3;
    int total = 0;
    int bad = 0;
    int d;
    bit found;

    assign readX = bx[readSel];
    assign readY = by[readSel];
    assign readZ = bz[readSel];
    assign readT = bt[readSel];

    always #5 clk = ~clk;

    telemetry_reader #(.NUM_TARGETS(NT)) dut (
        .clk(clk), .rst(rst), .start(start), .readSel(readSel),
        .readX(readX), .readY(readY), .readZ(readZ), .readT(readT),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .outLast(outLast), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int p);
        int t, b;
        logic [7:0] h;
        t = p / REC;
        b = p % REC;
        h = {4'hA, 4'(t)};
        case (b)
            0: return h;
            1: return ex[t];
            2: return ey[t];
            3: return ez[t];
            4: return et[t];
            default: return h ^ ex[t] ^ ey[t] ^ ez[t] ^ et[t];
        endcase
    endfunction

    // Called at the negedge where start has just been driven; returns the cycle index of done.
    task automatic collect(input int mode, input bit clr_start, output int dcyc);
        int c;
        bit hv;
        logic [7:0] held;
        c = 0; hv = 0; held = 8'd0;
        nb = 0; lastcnt = 0; lastidx = -1; dcyc = -1;
        while (c < 3000 && dcyc < 0) begin
            @(negedge clk);
            c++;
            if (clr_start) start = 1'b0;
            if (mode == 0) outReady = 1'b1;
            else           outReady = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
            if (c == 1) begin
                chk("addr_busy", busy, 1);
                chk("addr_sel", readSel, 0);
                chk("addr_valid", outValid, 0);
                chk("done_width", done, 0);
            end
            if (c == 2) chk("capt_valid", outValid, 0);
            if (c == 3) begin
                chk("first_valid", outValid, 1);
                chk("first_hdr", outData, 8'hA0);
            end
            if (hv) chk("stall_hold", outData, held);
            hv   = outValid && !outReady;
            held = outData;
            if (poke3 && outValid && outData == 8'hA3) bx[3] = 8'h77;
            if (outValid && outReady) begin
                got[nb] = outData;
                if (outLast) begin
                    lastcnt++;
                    lastidx = nb;
                end
                nb++;
            end
            if (done) begin
                dcyc = c;
                chk("done_busy", busy, 0);
            end
        end
    endtask

    task automatic verify(input int dcyc, input int mode);
        chk("done_seen", dcyc > 0, 1);
        chk("nbytes", nb, REC * NT);
        chk("last_count", lastcnt, 1);
        chk("last_pos", lastidx, REC * NT - 1);
        if (mode == 0) chk("done_cycle", dcyc, (REC + 2) * NT + 1);
        for (int p = 0; p < REC * NT; p++) chk($sformatf("byte%0d", p), got[p], exp_byte(p));
    endtask

    initial begin
        for (int n = 0; n < NT; n++) begin
            bx[n] = 8'(n);      by[n] = 8'(n + 16);
            bz[n] = 8'(n + 32); bt[n] = 8'(n + 48);
            ex[n] = bx[n]; ey[n] = by[n]; ez[n] = bz[n]; et[n] = bt[n];
        end
        poke3 = 0;
        rst = 1'b0; start = 1'b0; outReady = 1'b0;
        #1;
        chk("rst_valid", outValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel", readSel, 0);
        chk("rst_data", outData, 0);
        chk("rst_last", outLast, 0);
        #20;
        @(negedge clk) rst = 1'b1;

        // full sweep, ready high
        @(negedge clk) start = 1'b1;
        collect(0, 1, d);
        verify(d, 0);

        // ready toggling 1,0,0,1
        @(negedge clk) start = 1'b1;
        collect(1, 1, d);
        verify(d, 1);

        // start held high: back-to-back sweeps, none accepted mid-sweep
        @(negedge clk) start = 1'b1;
        collect(0, 0, d);
        verify(d, 0);
        collect(0, 0, d);
        verify(d, 0);
        start = 1'b0;
        @(negedge clk);
        chk("held_idle", busy, 0);

        // asynchronous reset while target 5 sends Y
        @(negedge clk) start = 1'b1;
        outReady = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (outValid && readSel == 4'd5 && outData == 8'h15) found = 1;
            else @(negedge clk);
        end
        chk("reach_t5_y", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", outValid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sel", readSel, 0);
        chk("arst_data", outData, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("arst_stays_idle", busy, 0);
        start = 1'b1;
        collect(0, 1, d);
        verify(d, 0);

        // bank rewrite of target 3 after its capture
        poke3 = 1;
        @(negedge clk) start = 1'b1;
        collect(0, 1, d);
        verify(d, 0);
        poke3 = 0;
        ex[3] = 8'h77;
        @(negedge clk) start = 1'b1;
        collect(0, 1, d);
        verify(d, 0);
        chk("new_x3", got[3 * REC + 1], 8'h77);

`ifdef TELEM_CHECKSUM_EN
        bx[2] = 8'h12; by[2] = 8'h34; bz[2] = 8'h56; bt[2] = 8'h78;
        ex[2] = 8'h12; ey[2] = 8'h34; ez[2] = 8'h56; et[2] = 8'h78;
        @(negedge clk) start = 1'b1;
        collect(0, 1, d);
        verify(d, 0);
        chk("csum_t2", got[2 * REC + 5], 8'hAA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
